// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the copter-side UART command endpoint.
// Optional inter-byte timeout is enabled with the UART_CMD_TIMEOUT_EN macro.
package uart_cmd_pkg;

   typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO} pkt_state_t;
   typedef enum logic {IDLE, SHIFT} tx_state_t;

   localparam logic [7:0] POS_ACK      = 8'hA5;
   localparam int         TIMEOUT_CLKS = 1_000_000;

endpackage

// File: rtl/uart_cmd_wrapper_rx.sv
// uart_rx_byte: RX synchronizer, start-edge detect, baud timing and deserializer.
// Emits each well-framed byte on rx_data with a one-cycle rx_rdy strobe.
module uart_rx_byte #(
   parameter int BAUD_DIV = 2604,
   parameter int HALF_DIV = BAUD_DIV / 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_rdy
);

   localparam int CW = $clog2(BAUD_DIV);

   logic          rx_s1, rx_s2, rx_prev;
   logic          busy;
   logic [CW-1:0] cnt;
   logic [3:0]    bit_idx;
   logic [7:0]    shreg;
   logic          sample;

   // bit_idx 0 is the start-bit midpoint, 1..8 data bits, 9 the stop bit
   assign sample = busy && (cnt == ((bit_idx == 4'd0) ? CW'(HALF_DIV - 1) : CW'(BAUD_DIV - 1)));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
         busy    <= 1'b0;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         rx_data <= '0;
         rx_rdy  <= 1'b0;
      end else begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
         rx_rdy  <= 1'b0;
         if (!busy) begin
            if (rx_prev && !rx_s2) begin
               busy    <= 1'b1;
               cnt     <= '0;
               bit_idx <= '0;
            end
         end else if (!sample) begin
            cnt <= cnt + 1'b1;
         end else begin
            cnt     <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 4'd0) begin
               if (rx_s2) busy <= 1'b0;   // glitch, not a real start bit
            end else if (bit_idx == 4'd9) begin
               busy <= 1'b0;
               if (rx_s2) begin
                  rx_data <= shreg;
                  rx_rdy  <= 1'b1;
               end
            end else begin
               shreg <= {rx_s2, shreg[7:1]};
            end
         end
      end
   end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper: assembles 3-byte host packets into cmd/data and serializes a response byte.
// Define UART_CMD_TIMEOUT_EN to drop partial packets after an inter-byte silence.
module uart_cmd_wrapper #(
   parameter int BAUD_DIV = 2604,
   parameter int HALF_DIV = BAUD_DIV / 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RX,
   output logic        TX,
   output logic [7:0]  cmd,
   output logic [15:0] data,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp,
   input  logic        send_resp,
   output logic        resp_sent,
   output logic        tx_busy
);
   import uart_cmd_pkg::*;

   localparam int CW = $clog2(BAUD_DIV);

   logic [7:0] rx_data;
   logic       rx_rdy;

   uart_rx_byte #(.BAUD_DIV(BAUD_DIV), .HALF_DIV(HALF_DIV)) u_rx (
      .clk     (clk),
      .rst     (rst),
      .rx      (RX),
      .rx_data (rx_data),
      .rx_rdy  (rx_rdy)
   );

   pkt_state_t pkt_state, pkt_next;
   logic [7:0]  cmd_sh, cmd_sh_n, hi_sh, hi_sh_n, cmd_n;
   logic [15:0] data_n;
   logic        rdy_n, timed_out;

`ifdef UART_CMD_TIMEOUT_EN
   logic [19:0] idle_cnt;
   assign timed_out = (pkt_state != WAIT_CMD) && (idle_cnt == 20'(TIMEOUT_CLKS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                          idle_cnt <= '0;
      else if (rx_rdy || timed_out || pkt_state == WAIT_CMD) idle_cnt <= '0;
      else                                              idle_cnt <= idle_cnt + 1'b1;
   end
`else
   assign timed_out = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_state <= WAIT_CMD;
         cmd_sh    <= '0;
         hi_sh     <= '0;
         cmd       <= '0;
         data      <= '0;
         cmd_rdy   <= 1'b0;
      end else begin
         pkt_state <= pkt_next;
         cmd_sh    <= cmd_sh_n;
         hi_sh     <= hi_sh_n;
         cmd       <= cmd_n;
         data      <= data_n;
         cmd_rdy   <= rdy_n;
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      pkt_next = pkt_state;
      cmd_sh_n = cmd_sh;
      hi_sh_n  = hi_sh;
      cmd_n    = cmd;
      data_n   = data;
      rdy_n    = cmd_rdy;
      if (clr_cmd_rdy) rdy_n = 1'b0;
      // completion is evaluated after the clear so it wins a same-cycle tie
      if (rx_rdy) begin
         case (pkt_state)
            WAIT_CMD: begin
               cmd_sh_n = rx_data;
               rdy_n    = 1'b0;
               pkt_next = WAIT_HI;
            end
            WAIT_HI: begin
               hi_sh_n  = rx_data;
               pkt_next = WAIT_LO;
            end
            WAIT_LO: begin
               cmd_n    = cmd_sh;
               data_n   = {hi_sh, rx_data};
               rdy_n    = 1'b1;
               pkt_next = WAIT_CMD;
            end
            default: pkt_next = WAIT_CMD;
         endcase
      end else if (timed_out) begin
         pkt_next = WAIT_CMD;
      end
   end

   tx_state_t   tx_state, tx_next;
   logic [9:0]  tx_shift, shift_n;
   logic [CW-1:0] tx_baud, baud_n;
   logic [3:0]  tx_bit, bit_n;
   logic        sent_n;

   // Idle-high shift register drives TX directly, so reset forces the line high at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state  <= IDLE;
         tx_shift  <= '1;
         tx_baud   <= '0;
         tx_bit    <= '0;
         resp_sent <= 1'b0;
      end else begin
         tx_state  <= tx_next;
         tx_shift  <= shift_n;
         tx_baud   <= baud_n;
         tx_bit    <= bit_n;
         resp_sent <= sent_n;
      end
   end

   always_comb begin
      tx_next = tx_state;
      shift_n = tx_shift;
      baud_n  = tx_baud;
      bit_n   = tx_bit;
      sent_n  = 1'b0;
      case (tx_state)
         IDLE: begin
            if (send_resp) begin
               shift_n = {1'b1, resp, 1'b0};
               baud_n  = '0;
               bit_n   = '0;
               tx_next = SHIFT;
            end
         end
         SHIFT: begin
            if (tx_baud == CW'(BAUD_DIV - 1)) begin
               baud_n = '0;
               if (tx_bit == 4'd9) begin
                  tx_next = IDLE;
                  sent_n  = 1'b1;
                  shift_n = '1;
               end else begin
                  shift_n = {1'b1, tx_shift[9:1]};
                  bit_n   = tx_bit + 1'b1;
               end
            end else begin
               baud_n = tx_baud + 1'b1;
            end
         end
         default: tx_next = IDLE;
      endcase
   end

   assign TX      = tx_shift[0];
   assign tx_busy = (tx_state == SHIFT);

endmodule
